// File: rtl/pwm_cfg_pkg.sv
// ----------------------------------------------------------------------------
// pwm_cfg_pkg
//   Shared definitions for the PWM configuration shadow block: register word
//   addresses, CTRL/STATUS bit positions and the commit FSM state encoding.
// ----------------------------------------------------------------------------
package pwm_cfg_pkg;

    // Word addresses on the configuration bus
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_THR1     = 3'd1;
    localparam logic [2:0] ADDR_THR2     = 3'd2;
    localparam logic [2:0] ADDR_PERIOD   = 3'd3;
    localparam logic [2:0] ADDR_STEP     = 3'd4;
    localparam logic [2:0] ADDR_INC_STEP = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    // CTRL register bits
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MODE_BIT   = 1;
    localparam int CTRL_COMMIT_BIT = 8;

    // STATUS register bits
    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_TIMEOUT_BIT = 1;
    localparam int STAT_CFGERR_BIT  = 2;

    // Commit sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } commit_state_e;

endpackage

// File: rtl/pwm_commit_fsm.sv
// ----------------------------------------------------------------------------
// pwm_commit_fsm
//   Sequences a software commit onto a PWM period boundary.
//   IDLE -> PENDING on an accepted commit; PENDING waits for period_end_i,
//   a disabled core, or the timeout; the apply strobe fires in that last
//   PENDING cycle so the active set is loaded at its closing edge, and the
//   following APPLY cycle drives the update pulse.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   commit_i         validated commit request (ignored while PENDING)
//   period_end_i     period boundary pulse from the PWM core
//   en_active_i      currently active enable (0 = core idle, apply at once)
//   apply_o          combinational strobe: load active <= staging this edge
//   pending_o        FSM is in PENDING
//   applied_o        FSM is in APPLY (cycle after active fields changed)
//   timeout_set_o    apply was forced by the timeout counter
// ----------------------------------------------------------------------------
module pwm_commit_fsm
    import pwm_cfg_pkg::*;
#(
    parameter int TimeoutCyc = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic commit_i,
    input  logic period_end_i,
    input  logic en_active_i,
    output logic apply_o,
    output logic pending_o,
    output logic applied_o,
    output logic timeout_set_o
);

    localparam int             CntW    = $clog2(TimeoutCyc);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCyc - 1);

    commit_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            cnt_last;

    assign cnt_last = (cnt_q == CntLast);

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counts only while waiting; held at its last value (saturates).
            if (state_q != ST_PENDING) begin
                cnt_q <= '0;
            end else if (!cnt_last) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        apply_o       = 1'b0;
        timeout_set_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (commit_i) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (period_end_i || !en_active_i || cnt_last) begin
                    apply_o       = 1'b1;
                    timeout_set_o = cnt_last;
                    state_d       = ST_APPLY;
                end
            end
            ST_APPLY: begin
                // A commit landing in the apply cycle queues the next set.
                state_d = commit_i ? ST_PENDING : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pending_o = (state_q == ST_PENDING);
    assign applied_o = (state_q == ST_APPLY);

endmodule

// File: rtl/pwm_config_shadow.sv
// ----------------------------------------------------------------------------
// pwm_config_shadow
//   Configuration front end for one PWM channel. Software writes a staging
//   set over a word bus and sets COMMIT; the staged set is copied atomically
//   into the active outputs at the next period boundary so the core never
//   sees a torn threshold/period/step combination.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   wr_en_i, rd_en_i       single-cycle write / read strobes
//   addr_i, wdata_i        word address and write data
//   rdata_o, rvalid_o      registered read data and its one-cycle valid
//   period_end_i           period boundary pulse from the PWM core
//   en_o, mode_o           active enable and mode (0 standard, 1 heartbeat)
//   thr1_o .. inc_step_o   active threshold/period/step fields
//   cfg_update_o           pulse in the cycle after the active set changed
//   pending_o              commit waiting for a boundary
// ----------------------------------------------------------------------------
module pwm_config_shadow
    import pwm_cfg_pkg::*;
#(
    parameter int Resolution = 16,
    parameter int DataWidth  = 32,
    parameter int TimeoutCyc = 65536
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [2:0]            addr_i,
    input  logic [DataWidth-1:0]  wdata_i,
    output logic [DataWidth-1:0]  rdata_o,
    output logic                  rvalid_o,
    input  logic                  period_end_i,
    output logic                  en_o,
    output logic                  mode_o,
    output logic [Resolution-1:0] thr1_o,
    output logic [Resolution-1:0] thr2_o,
    output logic [Resolution-1:0] period_o,
    output logic [Resolution-1:0] step_o,
    output logic [Resolution-1:0] inc_step_o,
    output logic                  cfg_update_o,
    output logic                  pending_o
);

    typedef struct packed {
        logic                  en;
        logic                  mode;
        logic [Resolution-1:0] thr1;
        logic [Resolution-1:0] thr2;
        logic [Resolution-1:0] period;
        logic [Resolution-1:0] step;
        logic [Resolution-1:0] inc_step;
    } cfg_t;

    cfg_t                  stg_q;
    cfg_t                  act_q;
    logic                  cfg_err_q;
    logic                  timeout_q;
    logic [DataWidth-1:0]  rdata_q;
    logic                  rvalid_q;
    logic [DataWidth-1:0]  rd_mux;

    logic                  ctrl_wr;
    logic                  stat_wr;
    logic                  commit_wr;
    logic                  set_valid;
    logic                  commit_ok;
    logic                  cfg_err_set;
    logic                  apply;
    logic                  pending;
    logic                  applied;
    logic                  timeout_set;
    logic [Resolution-1:0] wfield;
    logic                  unused_wdata_hi;

    assign wfield          = wdata_i[Resolution-1:0];
    assign unused_wdata_hi = ^wdata_i[DataWidth-1:Resolution];

    assign ctrl_wr   = wr_en_i && (addr_i == ADDR_CTRL);
    assign stat_wr   = wr_en_i && (addr_i == ADDR_STATUS);
    assign commit_wr = ctrl_wr && wdata_i[CTRL_COMMIT_BIT];

    // The mode being written with COMMIT decides whether INC_STEP matters;
    // the numeric fields are taken from staging as it stands this cycle.
    assign set_valid = (stg_q.period != '0) &&
                       !(wdata_i[CTRL_MODE_BIT] && (stg_q.inc_step == '0));
    assign commit_ok = commit_wr && set_valid;
    // A commit while already pending is ignored entirely, so it cannot fail.
    assign cfg_err_set = commit_wr && !set_valid && !pending;

    pwm_commit_fsm #(
        .TimeoutCyc(TimeoutCyc)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .commit_i     (commit_ok),
        .period_end_i (period_end_i),
        .en_active_i  (act_q.en),
        .apply_o      (apply),
        .pending_o    (pending),
        .applied_o    (applied),
        .timeout_set_o(timeout_set)
    );

    // Staging register bank
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_q <= '0;
        end else if (wr_en_i) begin
            unique case (addr_i)
                ADDR_CTRL: begin
                    stg_q.en   <= wdata_i[CTRL_EN_BIT];
                    stg_q.mode <= wdata_i[CTRL_MODE_BIT];
                end
                ADDR_THR1:     stg_q.thr1     <= wfield;
                ADDR_THR2:     stg_q.thr2     <= wfield;
                ADDR_PERIOD:   stg_q.period   <= wfield;
                ADDR_STEP:     stg_q.step     <= wfield;
                ADDR_INC_STEP: stg_q.inc_step <= wfield;
                default: ;
            endcase
        end
    end

    // Active set: whole-struct copy on apply; a CTRL write with enable=0
    // drops en immediately and takes priority over a simultaneous apply.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q <= '0;
        end else begin
            if (apply) act_q <= stg_q;
            if (ctrl_wr && !wdata_i[CTRL_EN_BIT]) act_q.en <= 1'b0;
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (cfg_err_set) begin
                cfg_err_q <= 1'b1;
            end else if (stat_wr && wdata_i[STAT_CFGERR_BIT]) begin
                cfg_err_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (stat_wr && wdata_i[STAT_TIMEOUT_BIT]) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // Read mux over pre-edge staging, so a same-cycle write reads the old value
    always_comb begin
        rd_mux = '0;
        unique case (addr_i)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN_BIT]   = stg_q.en;
                rd_mux[CTRL_MODE_BIT] = stg_q.mode;
            end
            ADDR_THR1:     rd_mux[Resolution-1:0] = stg_q.thr1;
            ADDR_THR2:     rd_mux[Resolution-1:0] = stg_q.thr2;
            ADDR_PERIOD:   rd_mux[Resolution-1:0] = stg_q.period;
            ADDR_STEP:     rd_mux[Resolution-1:0] = stg_q.step;
            ADDR_INC_STEP: rd_mux[Resolution-1:0] = stg_q.inc_step;
            ADDR_STATUS: begin
                rd_mux[STAT_PENDING_BIT] = pending;
                rd_mux[STAT_TIMEOUT_BIT] = timeout_q;
                rd_mux[STAT_CFGERR_BIT]  = cfg_err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en_i;
            rdata_q  <= rd_en_i ? rd_mux : '0;
        end
    end

    assign rdata_o      = rdata_q;
    assign rvalid_o     = rvalid_q;
    assign en_o         = act_q.en;
    assign mode_o       = act_q.mode;
    assign thr1_o       = act_q.thr1;
    assign thr2_o       = act_q.thr2;
    assign period_o     = act_q.period;
    assign step_o       = act_q.step;
    assign inc_step_o   = act_q.inc_step;
    assign cfg_update_o = applied;
    assign pending_o    = pending;

endmodule

// File: tb/tb_pwm_config_shadow.sv
// ----------------------------------------------------------------------------
// tb_pwm_config_shadow
//   Directed steps followed by random traffic, every cycle compared against
//   a register-array reference model of the configuration shadow.
// ----------------------------------------------------------------------------
module tb_pwm_config_shadow;

    localparam int RES = 16;
    localparam int DW  = 32;
    localparam int TO  = 16;

    logic           clk_i;
    logic           rst_i;
    logic           wr_en_i;
    logic           rd_en_i;
    logic [2:0]     addr_i;
    logic [DW-1:0]  wdata_i;
    logic [DW-1:0]  rdata_o;
    logic           rvalid_o;
    logic           period_end_i;
    logic           en_o;
    logic           mode_o;
    logic [RES-1:0] thr1_o;
    logic [RES-1:0] thr2_o;
    logic [RES-1:0] period_o;
    logic [RES-1:0] step_o;
    logic [RES-1:0] inc_step_o;
    logic           cfg_update_o;
    logic           pending_o;

    pwm_config_shadow #(
        .Resolution(RES),
        .DataWidth (DW),
        .TimeoutCyc(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .rd_en_i     (rd_en_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .period_end_i(period_end_i),
        .en_o        (en_o),
        .mode_o      (mode_o),
        .thr1_o      (thr1_o),
        .thr2_o      (thr2_o),
        .period_o    (period_o),
        .step_o      (step_o),
        .inc_step_o  (inc_step_o),
        .cfg_update_o(cfg_update_o),
        .pending_o   (pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: staging and active sets as arrays indexed by register
    // address (index 0 holds {mode, enable}).
    int unsigned   m_stg [6];
    int unsigned   m_act [6];
    bit            m_pend;
    int            m_wait;
    bit            m_upd;
    bit            m_err;
    bit            m_to;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_stg[i] = 0;
            m_act[i] = 0;
        end
        m_pend   = 1'b0;
        m_wait   = 0;
        m_upd    = 1'b0;
        m_err    = 1'b0;
        m_to     = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        bit            ctrl_wr, commit, valid, fire, n_pend;
        int            n_wait;
        logic [DW-1:0] rd_val;
        if (rst_i) begin
            model_reset();
            return;
        end
        rd_val = '0;
        if (addr_i <= 3'd5) rd_val = DW'(m_stg[addr_i]);
        else if (addr_i == 3'd6) rd_val = DW'({m_err, m_to, m_pend});

        ctrl_wr = wr_en_i && (addr_i == 3'd0);
        commit  = ctrl_wr && wdata_i[8];
        valid   = (m_stg[3] != 0) && !(wdata_i[1] && (m_stg[5] == 0));
        fire    = m_pend && (period_end_i || (m_act[0][0] == 1'b0) || (m_wait == TO - 1));
        n_pend  = m_pend ? !fire : (commit && valid);
        n_wait  = (m_pend && !fire) ? m_wait + 1 : 0;

        if (wr_en_i && addr_i == 3'd6 && wdata_i[2]) m_err = 1'b0;
        if (commit && !valid && !m_pend) m_err = 1'b1;
        if (wr_en_i && addr_i == 3'd6 && wdata_i[1]) m_to = 1'b0;
        if (m_pend && m_wait == TO - 1) m_to = 1'b1;

        if (fire) m_act = m_stg;
        if (ctrl_wr && !wdata_i[0]) m_act[0][0] = 1'b0;
        if (wr_en_i && addr_i == 3'd0) m_stg[0] = wdata_i & 32'h3;
        else if (wr_en_i && addr_i <= 3'd5) m_stg[addr_i] = wdata_i & 32'hFFFF;

        m_pend   = n_pend;
        m_wait   = n_wait;
        m_upd    = fire;
        m_rvalid = rd_en_i;
        m_rdata  = rd_en_i ? rd_val : '0;
    endtask

    task automatic compare_all();
        check("en_o",         en_o,         m_act[0][0]);
        check("mode_o",       mode_o,       m_act[0][1]);
        check("thr1_o",       thr1_o,       m_act[1]);
        check("thr2_o",       thr2_o,       m_act[2]);
        check("period_o",     period_o,     m_act[3]);
        check("step_o",       step_o,       m_act[4]);
        check("inc_step_o",   inc_step_o,   m_act[5]);
        check("cfg_update_o", cfg_update_o, m_upd);
        check("pending_o",    pending_o,    m_pend);
        check("rvalid_o",     rvalid_o,     m_rvalid);
        check("rdata_o",      rdata_o,      m_rdata);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [DW-1:0] d);
        wr_en_i = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] a, input logic [DW-1:0] exp);
        rd_en_i = 1'b1;
        addr_i  = a;
        tick();
        rd_en_i = 1'b0;
        check({tag, "_rvalid"}, rvalid_o, 1'b1);
        check(tag, rdata_o, exp);
    endtask

    initial begin
        rst_i        = 1'b1;
        wr_en_i      = 1'b0;
        rd_en_i      = 1'b0;
        addr_i       = '0;
        wdata_i      = '0;
        period_end_i = 1'b0;
        model_reset();
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state: every address reads 0, valid exactly one cycle later
        for (int a = 0; a < 8; a++) begin
            do_read("rst_read", 3'(a), '0);
            tick();
            check("rst_rvalid_drop", rvalid_o, 1'b0);
        end
        check("rst_en", en_o, 1'b0);

        // First commit from a disabled core applies without waiting
        do_write(3'd1, 32'd10);
        do_write(3'd2, 32'd200);
        do_write(3'd3, 32'd100);
        do_write(3'd4, 32'd3);
        do_write(3'd5, 32'd5);
        do_write(3'd0, 32'h103);
        check("c1_pending", pending_o, 1'b1);
        check("c1_thr1_held", thr1_o, 16'd0);
        tick();
        check("c1_thr1", thr1_o, 16'd10);
        check("c1_period", period_o, 16'd100);
        check("c1_mode", mode_o, 1'b1);
        check("c1_en", en_o, 1'b1);
        check("c1_update", cfg_update_o, 1'b1);
        tick();
        check("c1_update_drop", cfg_update_o, 1'b0);

        // Enabled core: commit waits for period_end_i
        do_write(3'd1, 32'd20);
        do_write(3'd0, 32'h103);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c2_wait_pending", pending_o, 1'b1);
            check("c2_wait_thr1", thr1_o, 16'd10);
        end
        period_end_i = 1'b1;
        tick();
        period_end_i = 1'b0;
        check("c2_thr1", thr1_o, 16'd20);
        check("c2_update", cfg_update_o, 1'b1);

        // Invalid set is rejected and flagged
        do_write(3'd3, 32'd0);
        do_write(3'd0, 32'h101);
        check("err_pending", pending_o, 1'b0);
        tick();
        check("err_period_kept", period_o, 16'd100);
        check("err_mode_kept", mode_o, 1'b1);
        do_read("err_status", 3'd6, 32'h4);
        do_write(3'd6, 32'h4);
        do_read("err_cleared", 3'd6, 32'h0);

        // Forced apply after TO cycles without a boundary
        do_write(3'd3, 32'd50);
        do_write(3'd0, 32'h103);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check("to_wait_pending", pending_o, 1'b1);
            check("to_wait_period", period_o, 16'd100);
        end
        tick();
        check("to_period", period_o, 16'd50);
        check("to_pending_drop", pending_o, 1'b0);
        do_read("to_status", 3'd6, 32'h2);
        do_write(3'd6, 32'h2);
        do_read("to_cleared", 3'd6, 32'h0);

        // Staging write in the boundary cycle is not part of the applied set
        do_write(3'd0, 32'h103);
        do_write(3'd1, 32'd77);
        period_end_i = 1'b1;
        do_write(3'd1, 32'd88);
        period_end_i = 1'b0;
        check("race_thr1", thr1_o, 16'd77);
        do_read("race_staged", 3'd1, 32'd88);

        // Disable bypasses the commit path
        do_write(3'd0, 32'h000);
        check("bypass_en", en_o, 1'b0);
        check("bypass_thr1", thr1_o, 16'd77);

        // Reset while a commit is pending
        do_write(3'd0, 32'h103);
        tick();
        check("re_en", en_o, 1'b1);
        do_write(3'd0, 32'h103);
        check("rp_pending", pending_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rp_pending_clr", pending_o, 1'b0);
        check("rp_en", en_o, 1'b0);
        check("rp_thr1", thr1_o, 16'd0);
        do_read("rp_staged", 3'd1, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [DW-1:0] d;
            rst_i        = ($urandom_range(0, 399) == 0);
            wr_en_i      = ($urandom_range(0, 99) < 30);
            rd_en_i      = ($urandom_range(0, 99) < 30);
            addr_i       = 3'($urandom_range(0, 7));
            period_end_i = ($urandom_range(0, 99) < 8);
            d = $urandom;
            if ($urandom_range(0, 9) == 0) d = '0;
            if (addr_i == 3'd0) begin
                d = '0;
                d[8] = ($urandom_range(0, 1) == 1);
                d[1] = ($urandom_range(0, 1) == 1);
                d[0] = ($urandom_range(0, 4) != 0);
            end
            wdata_i = d;
            tick();
        end
        rst_i        = 1'b0;
        wr_en_i      = 1'b0;
        rd_en_i      = 1'b0;
        period_end_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
